pc_fetch_unit: RTL and testbench

- Instruction-fetch stage that owns the program counter and issues word fetches to instruction memory.
- Holds each fetched word for decode under a valid/ready handshake.
- Accepts redirects from the branch/jump path. The branch offset arrives already shifted left by two (byte offset), straight from the shifter stage.
- Computes the branch target as base PC + offset and the jump target from the 26-bit index.

---
 rtl/pc_fetch_unit_if.sv | 46 ++++
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Bus bundle for pc_fetch_unit: the redirect inputs, the instruction-memory
// request/response channel, the decode hand-off and a state debug tap.
//
// Handshakes (the same rule applies to every channel):
//   - Memory request: the request transfers on a rising edge where IMemReq
//     and IMemGnt are both high. IMemAddr is stable while IMemReq is high
//     and no redirect is applied.
//   - Memory response: the memory returns one IMemRvalid pulse, carrying
//     IMemRdata, for each accepted request.
//   - Decode: the instruction transfers on a rising edge where InstrValid
//     and DecodeReady are both high. InstrOut and InstrPC hold their values
//     until that edge.
interface pc_fetch_unit_if;
    logic        BranchTaken;
    logic [31:0] BranchOffset;
    logic [31:0] RedirectBasePC;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRvalid;
    logic [31:0] IMemRdata;
    logic        InstrValid;
    logic [31:0] InstrOut;
    logic [31:0] InstrPC;
    logic        DecodeReady;
    logic        AddrError;
    logic [1:0]  FetchState;

    // Fetch-unit side
    modport master (
        input  BranchTaken, BranchOffset, RedirectBasePC, Jump, JumpIndex,
        input  IMemGnt, IMemRvalid, IMemRdata, DecodeReady,
        output IMemReq, IMemAddr, InstrValid, InstrOut, InstrPC, AddrError,
        output FetchState
    );

    // Environment side (memory, decode, branch unit)
    modport slave (
        output BranchTaken, BranchOffset, RedirectBasePC, Jump, JumpIndex,
        output IMemGnt, IMemRvalid, IMemRdata, DecodeReady,
        input  IMemReq, IMemAddr, InstrValid, InstrOut, InstrPC, AddrError,
        input  FetchState
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage. It owns the PC, issues one word fetch at a time,
// and holds the returned word for decode. Branch and jump redirects can
// arrive in any state. If a redirect lands while a fetch is in flight, the
// stale response is discarded.
//
// Optional build macro FETCH_MISALIGN_TRAP_EN:
//   - Defined: a redirect target with nonzero low bits raises a sticky
//     AddrError and freezes fetch until reset.
//   - Undefined: the low two target bits are cleared, and AddrError stays 0.
//
// FetchState exposes the FSM encoding: 0 = S_REQ, 1 = S_WAIT, 2 = S_HOLD.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic            Clk,
    input  logic            Reset,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        discard;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        addr_error;

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        target_bad;

    // Redirect target selection; branch wins over jump when both are asserted
    always_comb begin
        redirect   = bus.BranchTaken | bus.Jump;
        raw_target = bus.BranchTaken ? (bus.RedirectBasePC + bus.BranchOffset)
                                     : {bus.RedirectBasePC[31:28], bus.JumpIndex, 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
        target     = raw_target;
        target_bad = redirect && (raw_target[1:0] != 2'b00);
`else
        target     = raw_target & 32'hFFFF_FFFC;
        target_bad = 1'b0;
`endif
    end

    // Fetch FSM: PC, outstanding-request bookkeeping and the decode holding register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            req_pc      <= 32'h0;
            discard     <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= 32'h0;
            instr_pc    <= 32'h0;
            addr_error  <= 1'b0;
        end else if (addr_error) begin
            // Trapped: everything stays frozen until reset
            state <= S_REQ;
        end else if (target_bad) begin
            // A misaligned target is never loaded. A request still in flight
            // (or granted this cycle) is marked for discard.
            addr_error  <= 1'b1;
            instr_valid <= 1'b0;
            state       <= S_REQ;
            discard     <= ((state == S_REQ) && bus.IMemGnt) ||
                           ((state == S_WAIT) && !bus.IMemRvalid);
        end else begin
            case (state)
                S_REQ: begin
                    if (bus.IMemGnt) begin
                        // The old PC goes out even if a redirect arrives in
                        // the same cycle; its data is then marked for discard.
                        req_pc <= pc;
                        state  <= S_WAIT;
                        if (redirect) begin
                            discard <= 1'b1;
                            pc      <= target;
                        end else begin
                            pc <= pc + PC_STEP;
                        end
                    end else if (redirect) begin
                        pc <= target;
                    end
                end
                S_WAIT: begin
                    if (bus.IMemRvalid) begin
                        discard <= 1'b0;
                        if (discard || redirect) begin
                            state <= S_REQ;
                            if (redirect) pc <= target;
                        end else begin
                            instr_out   <= bus.IMemRdata;
                            instr_pc    <= req_pc;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (redirect) begin
                        pc      <= target;
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        pc          <= target;
                        state       <= S_REQ;
                    end else if (bus.DecodeReady) begin
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    assign bus.IMemReq    = (state == S_REQ) && !Reset && !addr_error;
    assign bus.IMemAddr   = pc;
    assign bus.InstrValid = instr_valid;
    assign bus.InstrOut   = instr_out;
    assign bus.InstrPC    = instr_pc;
    assign bus.AddrError  = addr_error;
    assign bus.FetchState = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. The reference model tracks what is in
// flight: the PC, at most one outstanding fetch (with a keep/drop flag),
// the instruction held for decode, and the trap flag. A compare process
// checks every DUT output against the model on every cycle. Directed
// scenarios pin specific values, and a randomized phase follows them.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk;
    logic rst;
    pc_fetch_unit_if bus_if();

    pc_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus_if.master)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and model state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] m_pc       = RST_PC;
    logic        m_pend     = 1'b0;
    logic        m_keep     = 1'b0;
    logic [31:0] m_pend_pc  = 32'h0;
    logic        m_held     = 1'b0;
    logic [31:0] m_out      = 32'h0;
    logic [31:0] m_out_pc   = 32'h0;
    logic        m_err      = 1'b0;

    logic [31:0] acc_log[$];
    logic [31:0] xfer_pc[$];
    int          xfer_cyc[$];

    // memory responder knobs
    int gnt_mode = 1;   // 0 never, 1 always when free, 2 random
    int dly_min  = 0;
    int dly_max  = 0;
    int spur_en  = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ok(input string name, input logic ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: wait expired after 64 cycles, got 0 expected 1", name);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        r_redirect;
    logic [31:0] r_tgt;
    logic        r_bad;
    logic        r_req;
    always @(posedge clk) begin
        cyc++;
        if (bus_if.InstrValid && bus_if.DecodeReady && !bus_if.BranchTaken &&
            !bus_if.Jump && !rst) begin
            xfer_pc.push_back(bus_if.InstrPC);
            xfer_cyc.push_back(cyc);
        end
        r_req      = !rst && !m_pend && !m_held && !m_err;
        r_redirect = bus_if.BranchTaken || bus_if.Jump;
        if (bus_if.BranchTaken) r_tgt = bus_if.RedirectBasePC + bus_if.BranchOffset;
        else r_tgt = {bus_if.RedirectBasePC[31:28], bus_if.JumpIndex, 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
        r_bad = r_redirect && (r_tgt % 4 != 0);
`else
        r_bad = 1'b0;
        r_tgt = r_tgt - (r_tgt % 4);
`endif
        if (rst) begin
            m_pc = RST_PC; m_pend = 0; m_keep = 0; m_held = 0;
            m_out = 0; m_out_pc = 0; m_err = 0;
        end else if (m_err) begin
            if (m_pend && bus_if.IMemRvalid) m_pend = 0;
        end else if (r_bad) begin
            m_err  = 1;
            m_held = 0;
            if (r_req && bus_if.IMemGnt) begin
                m_pend = 1; m_keep = 0; m_pend_pc = m_pc; acc_log.push_back(m_pc);
            end else if (m_pend && bus_if.IMemRvalid) m_pend = 0;
            else m_keep = 0;
        end else if (m_held) begin
            if (r_redirect) begin m_held = 0; m_pc = r_tgt; end
            else if (bus_if.DecodeReady) m_held = 0;
        end else if (m_pend) begin
            if (bus_if.IMemRvalid) begin
                m_pend = 0;
                if (m_keep && !r_redirect) begin
                    m_held = 1; m_out = bus_if.IMemRdata; m_out_pc = m_pend_pc;
                end
                if (r_redirect) m_pc = r_tgt;
            end else if (r_redirect) begin
                m_pc = r_tgt; m_keep = 0;
            end
        end else if (r_req && bus_if.IMemGnt) begin
            m_pend = 1; m_keep = !r_redirect; m_pend_pc = m_pc;
            acc_log.push_back(m_pc);
            m_pc = r_redirect ? r_tgt : m_pc + 32'd4;
        end else if (r_redirect) begin
            m_pc = r_tgt;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(posedge clk) begin
        #1;
        chk("imem_req",    bus_if.IMemReq,    {31'h0, (!rst && !m_pend && !m_held && !m_err)});
        chk("imem_addr",   bus_if.IMemAddr,   m_pc);
        chk("instr_valid", bus_if.InstrValid, {31'h0, m_held});
        chk("instr_out",   bus_if.InstrOut,   m_out);
        chk("instr_pc",    bus_if.InstrPC,    m_out_pc);
        chk("addr_error",  bus_if.AddrError,  {31'h0, m_err});
    end

    // ---------------- memory responder ----------------
    initial begin
        bus_if.IMemGnt = 1'b0; bus_if.IMemRvalid = 1'b0; bus_if.IMemRdata = 32'h0;
        forever begin
            @(posedge clk);
            if (bus_if.IMemRvalid) mem_busy = 1'b0;
            if (bus_if.IMemReq && bus_if.IMemGnt) begin
                mem_busy = 1'b1;
                mem_addr = bus_if.IMemAddr;
                mem_cnt  = $urandom_range(dly_max, dly_min);
            end
            @(negedge clk);
            bus_if.IMemRvalid = 1'b0;
            bus_if.IMemRdata  = $urandom;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    bus_if.IMemRvalid = 1'b1;
                    bus_if.IMemRdata  = mem_word(mem_addr);
                end else mem_cnt--;
            end else if (spur_en != 0 && $urandom_range(7, 0) == 0) begin
                bus_if.IMemRvalid = 1'b1;
            end
            bus_if.IMemGnt = !mem_busy && (gnt_mode == 1 ||
                             (gnt_mode == 2 && $urandom_range(3, 0) != 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_redirect();
        bus_if.BranchTaken = 1'b0;
        bus_if.Jump        = 1'b0;
    endtask

    task automatic wait_held(input string name);
        int i = 0;
        while (!m_held && i < 64) begin tick(); i++; end
        wait_ok(name, m_held);
    endtask

    task automatic wait_pend(input string name);
        int i = 0;
        while (!m_pend && i < 64) begin tick(); i++; end
        wait_ok(name, m_pend);
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while ((m_pend || m_held) && i < 64) begin tick(); i++; end
        wait_ok(name, !m_pend && !m_held);
    endtask

    // ---------------- stimulus ----------------
    logic        saw_valid;
    logic [31:0] h_data;
    logic [31:0] h_pc;
    int          nx;
    int          wi;
    initial begin
        rst = 1'b1;
        clear_redirect();
        bus_if.BranchOffset = 32'h0; bus_if.RedirectBasePC = 32'h0;
        bus_if.JumpIndex = 26'h0; bus_if.DecodeReady = 1'b1;
        repeat (2) tick();

        // Reset values and straight-line fetch
        chk("rst_req", bus_if.IMemReq, 32'd0);
        chk("rst_addr", bus_if.IMemAddr, RST_PC);
        chk("rst_valid", bus_if.InstrValid, 32'd0);
        chk("rst_out", bus_if.InstrOut, 32'd0);
        chk("rst_pc", bus_if.InstrPC, 32'd0);
        chk("rst_err", bus_if.AddrError, 32'd0);
        acc_log.delete(); xfer_pc.delete(); xfer_cyc.delete();
        rst = 1'b0;
        repeat (12) tick();
        chk("seq_acc0", acc_log[0], 32'h0040_0000);
        chk("seq_acc1", acc_log[1], 32'h0040_0004);
        chk("seq_acc2", acc_log[2], 32'h0040_0008);
        chk("seq_xfer_n", xfer_pc.size(), 32'd4);
        chk("seq_xfer0", xfer_pc[0], 32'h0040_0000);
        chk("seq_xfer1", xfer_pc[1], 32'h0040_0004);
        chk("seq_xfer2", xfer_pc[2], 32'h0040_0008);
        chk("seq_gap01", xfer_cyc[1] - xfer_cyc[0], 32'd3);
        chk("seq_gap12", xfer_cyc[2] - xfer_cyc[1], 32'd3);

        // Branch while an instruction is held: the instruction is killed
        bus_if.DecodeReady = 1'b0;
        wait_held("wait_hold_br");
        dly_min = 3; dly_max = 3;
        nx = xfer_pc.size();
        bus_if.BranchTaken = 1'b1; bus_if.RedirectBasePC = 32'h0040_0008;
        bus_if.BranchOffset = 32'hFFFF_FFF8; bus_if.DecodeReady = 1'b1;
        tick();
        clear_redirect();
        chk("br_addr", bus_if.IMemAddr, 32'h0040_0000);
        chk("br_model_pc", m_pc, 32'h0040_0000);
        chk("br_valid", bus_if.InstrValid, 32'd0);
        chk("br_no_xfer", xfer_pc.size(), nx);

        // Jump while a fetch is outstanding: the response is dropped
        wait_pend("wait_pend_jmp");
        bus_if.Jump = 1'b1; bus_if.JumpIndex = 26'h010_0040;
        bus_if.RedirectBasePC = 32'h1000_0000;
        tick();
        clear_redirect();
        saw_valid = 1'b0; wi = 0;
        while (m_pend && wi < 64) begin saw_valid |= bus_if.InstrValid; tick(); wi++; end
        saw_valid |= bus_if.InstrValid;
        wait_ok("wait_jmp_drain", !m_pend);
        chk("jmp_no_valid", saw_valid, 32'd0);
        chk("jmp_addr", bus_if.IMemAddr, 32'h1040_0100);
        chk("jmp_req", bus_if.IMemReq, 32'd1);

        // Decode backpressure for five cycles
        bus_if.DecodeReady = 1'b0;
        wait_held("wait_hold_bp");
        h_data = m_out; h_pc = m_out_pc;
        chk("bp_model_data", h_data, mem_word(32'h1040_0100));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", bus_if.InstrValid, 32'd1);
            chk("bp_out", bus_if.InstrOut, h_data);
            chk("bp_pc", bus_if.InstrPC, h_pc);
            chk("bp_req", bus_if.IMemReq, 32'd0);
        end
        nx = xfer_pc.size();
        bus_if.DecodeReady = 1'b1;
        tick();
        chk("bp_rel_valid", bus_if.InstrValid, 32'd0);
        chk("bp_rel_req", bus_if.IMemReq, 32'd1);
        chk("bp_rel_xfer", xfer_pc.size(), nx + 1);
        chk("bp_rel_pc", xfer_pc[nx], 32'h1040_0100);

        // PC wrap at the top of the address space
        gnt_mode = 0;
        wait_idle("wait_idle_wrap");
        bus_if.BranchTaken = 1'b1; bus_if.RedirectBasePC = 32'hFFFF_FFF8;
        bus_if.BranchOffset = 32'h0000_0004;
        tick();
        clear_redirect();
        chk("wrap_addr_top", bus_if.IMemAddr, 32'hFFFF_FFFC);
        gnt_mode = 1;
        wait_pend("wait_pend_wrap");
        chk("wrap_addr_zero", bus_if.IMemAddr, 32'h0000_0000);
        chk("wrap_acc", acc_log[acc_log.size() - 1], 32'hFFFF_FFFC);

        // Branch and jump together: the branch target wins
        gnt_mode = 0;
        wait_idle("wait_idle_both");
        bus_if.BranchTaken = 1'b1; bus_if.Jump = 1'b1;
        bus_if.RedirectBasePC = 32'h0040_0010; bus_if.BranchOffset = 32'h0000_0020;
        bus_if.JumpIndex = 26'h3FF_FFFF;
        tick();
        clear_redirect();
        chk("both_addr", bus_if.IMemAddr, 32'h0040_0030);

        // Reset while waiting, then a late response arrives
        gnt_mode = 1;
        wait_pend("wait_pend_rst");
        rst = 1'b1;
        tick();
        chk("midrst_req", bus_if.IMemReq, 32'd0);
        chk("midrst_addr", bus_if.IMemAddr, RST_PC);
        chk("midrst_valid", bus_if.InstrValid, 32'd0);
        acc_log.delete();
        rst = 1'b0;
        saw_valid = 1'b0; wi = 0;
        while (acc_log.size() == 0 && wi < 64) begin saw_valid |= bus_if.InstrValid; tick(); wi++; end
        wait_ok("wait_acc_after_rst", acc_log.size() != 0);
        chk("midrst_no_valid", saw_valid, 32'd0);
        chk("midrst_acc", acc_log[0], RST_PC);

        // Misaligned redirect target
        gnt_mode = 0; dly_min = 0; dly_max = 0;
        wait_idle("wait_idle_mis");
        bus_if.BranchTaken = 1'b1; bus_if.RedirectBasePC = 32'h0040_0000;
        bus_if.BranchOffset = 32'h0000_0002;
        tick();
        clear_redirect();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_err", bus_if.AddrError, 32'd1);
        chk("mis_req", bus_if.IMemReq, 32'd0);
        gnt_mode = 1;
        repeat (3) tick();
        chk("mis_err_sticky", bus_if.AddrError, 32'd1);
        chk("mis_req_frozen", bus_if.IMemReq, 32'd0);
        rst = 1'b1;
        tick();
        chk("mis_err_clr", bus_if.AddrError, 32'd0);
        rst = 1'b0;
`else
        chk("mis_addr", bus_if.IMemAddr, 32'h0040_0000);
        chk("mis_err", bus_if.AddrError, 32'd0);
        chk("mis_req", bus_if.IMemReq, 32'd1);
`endif

        // Randomized traffic
        gnt_mode = 2; dly_min = 0; dly_max = 2; spur_en = 1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199, 0) == 0);
            bus_if.BranchTaken = ($urandom_range(9, 0) == 0);
            bus_if.Jump = ($urandom_range(9, 0) == 0);
            bus_if.RedirectBasePC = $urandom & 32'hFFFF_FFFC;
            bus_if.BranchOffset = ($urandom_range(7, 0) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            bus_if.JumpIndex = 26'($urandom);
            bus_if.DecodeReady = ($urandom_range(3, 0) != 0);
            tick();
        end
        rst = 1'b0;
        clear_redirect();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
